// File: rtl/rv_pkg.sv
// Purpose: shared constants and types for the integer register file.
//   XLEN     default data width
//   REG_AW   address width of the default 32-entry file
//   REG_ZERO architectural zero register index
//   REG_T0   register mirrored onto the LED tap by default
//   rf_state_e  clear sequencer states
package rv_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int REG_ZERO = 0;
  localparam int REG_T0   = 5;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Purpose: per-entry pending bits for the register file, plus the per-port
//   hazard lookup.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   clr_en, clr_addr   clear sequencer zeroing one entry
//   wr_en, wr_addr     writeback retiring a producer (clears pending)
//   mark_en, mark_addr issue of a producer (sets pending)
//   rd_en              per-port read enable, already gated by ready
//   ra                 packed read addresses, port i at [i*AW +: AW]
//   byp_hit            per-port same-cycle write match (bypass active)
//   hazard             per-port source pending and not bypassed
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr_en,
  input  logic [AW-1:0]       clr_addr,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic                mark_en,
  input  logic [AW-1:0]       mark_addr,
  input  logic [NREAD-1:0]    rd_en,
  input  logic [NREAD*AW-1:0] ra,
  input  logic [NREAD-1:0]    byp_hit,
  output logic [NREAD-1:0]    hazard
);

  logic [DEPTH-1:0] pend_q, pend_d;

  // Mark is applied last so an issue and a retire to the same entry in one
  // cycle leaves the entry pending for the newer producer.
  always_comb begin
    pend_d = pend_q;
    if (clr_en)  pend_d[clr_addr]  = 1'b0;
    if (wr_en)   pend_d[wr_addr]   = 1'b0;
    if (mark_en) pend_d[mark_addr] = 1'b1;
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_hz
    logic [AW-1:0] ra_g;
    assign ra_g      = ra[g*AW +: AW];
    assign hazard[g] = rd_en[g] && pend_q[ra_g] && !byp_hit[g];
  end

endmodule

// File: rtl/regfile_mp.sv
// Purpose: multi-read-port integer register file with a hardware clear
//   sequencer, optional write-to-read bypass, pending scoreboard and a
//   registered LED tap of one entry.
// Ports:
//   clk, reset   clock, synchronous active-high reset (restarts the clear)
//   we, wa, wdata             writeback port
//   re, ra, rdata             NREAD combinational read ports (packed)
//   hazard                    per-port source pending and not bypassed
//   mark_en, mark_addr        mark an entry pending at issue
//   ready                     clear sequence finished
//   tap                       registered low bits of entry TAP_REG
//
// state    | meaning
// RF_CLEAR | zeroing entry clr_cnt each cycle; ports idle, writes ignored
// RF_READY | normal operation
module regfile_mp
  import rv_pkg::*;
#(
  parameter int XLEN     = rv_pkg::XLEN,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int TAP_REG  = rv_pkg::REG_T0,
  parameter int TAP_W    = 4,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [XLEN-1:0]       wdata,
  input  logic [NREAD-1:0]      re,
  input  logic [NREAD*AW-1:0]   ra,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      hazard,
  input  logic                  mark_en,
  input  logic [AW-1:0]         mark_addr,
  output logic                  ready,
  output logic [TAP_W-1:0]      tap
);

  localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] TAP_IDX  = AW'(TAP_REG);

  rf_state_e        state_q, state_d;
  logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
  logic [TAP_W-1:0] tap_q;

  logic             rdy;
  logic             wa_is_zero;
  logic             wr_ok;
  logic             mark_ok;
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [XLEN-1:0]  mem_wd;
  logic [XLEN-1:0]  mem_q [DEPTH];

  logic [NREAD-1:0] rd_en;
  logic [NREAD-1:0] byp_hit;

  assign wa_is_zero = (ZERO_REG != 0) && (wa == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RF_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      RF_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_LAST) state_d = RF_READY;
      end
      RF_READY: state_d = RF_READY;
      default:  state_d = RF_CLEAR;
    endcase
  end

  // Outputs: the single memory write port is shared by the sequencer and
  // writeback, muxed on state.
  always_comb begin
    rdy     = 1'b0;
    wr_ok   = 1'b0;
    mark_ok = 1'b0;
    mem_we  = 1'b0;
    mem_wa  = '0;
    mem_wd  = '0;
    case (state_q)
      RF_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = clr_cnt_q;
        mem_wd = '0;
      end
      RF_READY: begin
        rdy     = 1'b1;
        wr_ok   = we && !wa_is_zero;
        mark_ok = mark_en && !((ZERO_REG != 0) && (mark_addr == '0));
        mem_we  = wr_ok;
        mem_wa  = wa;
        mem_wd  = wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (reset) tap_q <= '0;
    else       tap_q <= mem_q[TAP_IDX][TAP_W-1:0];
  end

  assign ready = rdy;
  assign tap   = tap_q;

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] ra_g;
    logic          ra_zero;
    assign ra_g       = ra[g*AW +: AW];
    assign ra_zero    = (ZERO_REG != 0) && (ra_g == '0);
    assign rd_en[g]   = rdy && re[g];
    assign byp_hit[g] = (BYPASS != 0) && we && (wa == ra_g);
    // Zero register check precedes bypass so a write to x0 never leaks.
    assign rdata[g*XLEN +: XLEN] = (!rd_en[g] || ra_zero) ? '0 :
                                   byp_hit[g]             ? wdata :
                                                            mem_q[ra_g];
  end

  regfile_scoreboard #(
    .DEPTH   (DEPTH),
    .NREAD   (NREAD),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .clr_en   (!rdy),
    .clr_addr (clr_cnt_q),
    .wr_en    (wr_ok),
    .wr_addr  (wa),
    .mark_en  (mark_ok),
    .mark_addr(mark_addr),
    .rd_en    (rd_en),
    .ra       (ra),
    .byp_hit  (byp_hit),
    .hazard   (hazard)
  );

endmodule
